inv_keyexpansion: RTL
=====================

Name: inv_keyexpansion

Overview:
- Reverse AES-128 key schedule: takes the final round key (round 10) and regenerates round keys 10 down to 0, one per accepted beat.
- Feeds the decryption datapath, which consumes round keys in reverse order.
- Avoids storing the full 1408-bit forward schedule.
- Output is a valid/ready stream; the last key emitted (round 0) equals the original cipher key.

Parameters:
ROUNDS, 10, number of rounds; only 10 (AES-128) is supported, other values are out of scope.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
last_key  input  128  round-10 key; bits [127:96] = word w40, byte order per FIPS-197 (key[127:120] = byte 0)
start  input  1  single-cycle request; sampled only in IDLE
rk_data  output  128  current round key, same byte order as last_key
rk_round  output  4  round index of rk_data (10..0)
rk_valid  output  1  rk_data/rk_round valid
rk_ready  input  1  consumer accepts current key when high together with rk_valid
busy  output  1  high from start acceptance until finish pulse
finish  output  1  one-cycle pulse after round-0 key is accepted

Behaviour:
- Reset (rst low, async): state=IDLE. rk_data=0, rk_round=0, rk_valid=0, busy=0, finish=0.
- States: IDLE, EMIT, DONE.
- IDLE:
  - start=1 registers last_key into cur, rk_round=10, rk_valid=1, busy=1, then EMIT.
  - First key is visible the cycle after start (latency 1).
- EMIT:
  - rk_data=cur.
  - On handshake (rk_valid & rk_ready) with rk_round>0: cur <= prev(cur, Rcon[rk_round]), rk_round decrements, rk_valid stays 1.
  - On handshake with rk_round==0: rk_valid=0, go to DONE.
  - Without handshake: cur and rk_round hold and rk_valid stays high (stable data while stalled).
- DONE: finish=1 and busy=0 for exactly one cycle, then IDLE.
- With rk_ready held high, the 11 keys appear on 11 consecutive cycles and finish follows one cycle after the last.
- prev() step, with current words w0..w3 (w0 = bits [127:96]):
  - p3 = w3^w2
  - p2 = w2^w1
  - p1 = w1^w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[r],24'h0}
  - RotWord left-rotates bytes: {b1,b2,b3,b0}.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- Timing: the path is single-cycle, combinational cur -> 4 sbox -> xor -> cur register.
- Boundary conditions:
  - start while busy (EMIT or DONE): ignored, no restart.
  - start in the same cycle as DONE: ignored; accepted next cycle in IDLE.
  - last_key changes after start: no effect; it is sampled only at start acceptance.
  - rk_ready high while rk_valid low: no effect.
  - rst low mid-operation: immediate return to reset values; no finish pulse.
  - rk_round never wraps below 0.

Decomposition:
- Shared package:
  - AES_ROUNDS=10, KEY_W=128 constants.
  - Rcon table as a constant array indexed 1..10.
  - 32-bit word typedef.
  - RotWord function.
- Sub-modules:
  - Reuse the existing sbox module, instantiated 4 times for SubWord.
  - One combinational sub-module inv_key_step (inputs cur[127:0], rcon[7:0]; output prev[127:0]) holds the prev() equations.
  - The FSM and registers stay in inv_keyexpansion.

Test Plan:
- FIPS-197 A.1 streaming: last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, start, rk_ready=1 -> round10 = that value; round9 = ac7766f319fadc2128d12941575c006e; round1 = a0fafe1788542cb123a339392a6c7605; round0 = 2b7e151628aed2a6abf7158809cf4f3c; 11 consecutive valid cycles; finish one cycle later.
- Backpressure: same vector, rk_ready toggled pseudo-randomly -> identical 11-key sequence; rk_data/rk_round stable while rk_valid & !rk_ready.
- Start while busy: pulse start with a different last_key during EMIT -> ignored; sequence and finish unchanged.
- Mid-run reset: assert rst low after round 6 is accepted -> all outputs 0 asynchronously, no finish; new start afterwards yields the full 10..0 sequence.
- Round-trip: random keys through the existing forward keyexpansion, then its round-10 output into this block -> round-0 output equals the original key for 100 keys.
- Back-to-back: start asserted in the DONE cycle is ignored; start in the following cycle is accepted, and rk_valid rises one cycle later.

Source files
------------

// File: rtl/inv_keyexpansion_pkg.sv
// Shared constants and helpers for the reverse AES-128 key schedule.
// Holds the Rcon table, the word type, RotWord and the FSM state encoding.
package inv_keyexpansion_pkg;

  localparam int AES_ROUNDS = 10;
  localparam int KEY_W      = 128;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [7:0] RCON [1:AES_ROUNDS] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Round 0 and out-of-range indices map to zero so callers never index outside the table.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 1; i <= AES_ROUNDS; i++) begin
      if (r == 4'(i)) v = RCON[i];
    end
    return v;
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/inv_keyexpansion_step.sv
// One backward step of the AES-128 key schedule: round key r -> round key r-1.
// Combinational; rcon is Rcon[r] of the key being undone.
module inv_key_step
  import inv_keyexpansion_pkg::*;
(
  input  logic [KEY_W-1:0] cur,
  input  logic [7:0]       rcon,
  output logic [KEY_W-1:0] prev
);

  word_t w0, w1, w2, w3;
  word_t p0, p1, p2, p3;
  word_t rot, sub;

  assign w0 = cur[127:96];
  assign w1 = cur[95:64];
  assign w2 = cur[63:32];
  assign w3 = cur[31:0];

  assign p3  = w3 ^ w2;
  assign p2  = w2 ^ w1;
  assign p1  = w1 ^ w0;
  assign rot = rot_word(p3);

  for (genvar b = 0; b < 4; b++) begin : g_subword
    sbox u_sbox (
      .a (rot[8*b +: 8]),
      .y (sub[8*b +: 8])
    );
  end

  assign p0   = w0 ^ sub ^ {rcon, 24'h000000};
  assign prev = {p0, p1, p2, p3};

endmodule

// File: rtl/sbox.sv
// AES forward S-box: GF(2^8) multiplicative inverse followed by the affine map.
// Purely combinational.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = x;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // x^254 is the field inverse, and conveniently maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] res;
    logic [7:0] sq;
    res = 8'h01;
    sq  = x;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      res = gf_mul(res, sq);
    end
    return res;
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv = gf_inv(a);
    y   = inv
        ^ {inv[6:0], inv[7]}
        ^ {inv[5:0], inv[7:6]}
        ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]}
        ^ 8'h63;
  end

endmodule

// File: rtl/inv_keyexpansion.sv
// Reverse AES-128 key schedule: streams round keys 10 down to 0 from the round-10 key.
// One key per accepted valid/ready beat; finish pulses once after round 0 is taken.
module inv_keyexpansion
  import inv_keyexpansion_pkg::*;
#(
  parameter int ROUNDS = AES_ROUNDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] last_key,
  input  logic             start,
  output logic [KEY_W-1:0] rk_data,
  output logic [3:0]       rk_round,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             busy,
  output logic             finish
);

  state_t           state;
  logic [KEY_W-1:0] cur;
  logic [KEY_W-1:0] prev_key;
  logic             hs;

  inv_key_step u_step (
    .cur  (cur),
    .rcon (rcon_of(rk_round)),
    .prev (prev_key)
  );

  assign rk_data = cur;
  assign hs      = rk_valid & rk_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cur      <= '0;
      rk_round <= '0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      finish   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          finish <= 1'b0;
          if (start) begin
            cur      <= last_key;
            rk_round <= 4'(ROUNDS);
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (hs) begin
            if (rk_round != 4'd0) begin
              cur      <= prev_key;
              rk_round <= rk_round - 4'd1;
            end else begin
              // Round 0 taken: drop valid and raise finish for the single DONE cycle.
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              finish   <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        S_DONE: begin
          finish <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          rk_valid <= 1'b0;
          busy     <= 1'b0;
          finish   <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
